mem_port_arbiter: RTL

Arbiter and access sequencer for the single-ported unified instruction/data memory in the RV32I pipeline. It shares one memory port between the instruction-fetch requester and the load/store requester, issues at most one access per cycle, and routes read data back to the owning requester after a fixed memory latency. It also produces stall signals for the pipeline and starvation protection for fetch.

---
 rtl/rv32i_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter_resp_tag_pipe.sv | 33 +++
 rtl/mem_port_arbiter.sv | 75 +++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: memory-port owner encoding, response tag and default widths.
package rv32i_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } resp_tag_t;

endpackage : rv32i_pkg

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared instruction/data memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = rv32i_pkg::DEF_ADDR_W,
  parameter int DATA_W = rv32i_pkg::DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_d;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_d
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_d
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// DEPTH-stage {valid, owner} shift register that tracks which requester owns each
// read returning from the memory.
module resp_tag_pipe
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk1,
  input  logic      rst_n,
  input  resp_tag_t push_tag,
  output resp_tag_t tail_tag
);

  resp_tag_t [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = push_tag;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: non-blocking assignment so every stage samples the pre-edge value of its neighbour.
  // NOTE: unlike a data RAM, this array is reset: a stale valid bit would fake an rvalid.
  always_ff @(posedge clk1) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign tail_tag = pipe_q[DEPTH-1];

endmodule : resp_tag_pipe

// File: rtl/mem_port_arbiter.sv
// Shares the single unified memory port between fetch and load/store: one grant per
// cycle, data first unless fetch has been starved, read data routed back by owner tag.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               HALTED,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              if_gnt, d_gnt, fetch_first;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  resp_tag_t         push_tag, tail_tag;

  always_comb begin
    // NOTE: defaults first, so no branch below can leave a signal unassigned and infer a latch.
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    starve_d    = starve_q;
    fetch_first = bus.if_req && (starve_q == STARVE_LIM);

    if (rst_n && !HALTED) begin
      if (bus.d_req && !fetch_first) d_gnt  = 1'b1;
      else if (bus.if_req)           if_gnt = 1'b1;
    end

    // Counter freezes while halted so the fairness debt survives the halt.
    if (!HALTED) begin
      if (if_gnt || !bus.if_req) starve_d = '0;
      else if (d_gnt)            starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  assign mem_addr  = d_gnt ? bus.d_addr : bus.if_addr;
  assign mem_wdata = (d_gnt && bus.d_we) ? bus.d_wdata : '0;
  assign push_tag  = '{valid: (if_gnt || (d_gnt && !bus.d_we)),
                       owner: (d_gnt ? OWN_D : OWN_IF)};

  resp_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .push_tag (push_tag),
    .tail_tag (tail_tag)
  );

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt | d_gnt;
  assign bus.mem_we    = d_gnt & bus.d_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.stall_if  = bus.if_req & ~if_gnt;
  assign bus.stall_d   = bus.d_req & ~d_gnt;

  assign bus.if_rvalid = tail_tag.valid && (tail_tag.owner == OWN_IF);
  assign bus.d_rvalid  = tail_tag.valid && (tail_tag.owner == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;

endmodule : mem_port_arbiter
